// File: rtl/async_fifo_rd_ctrl_pkg.sv
// Gray/binary pointer helpers shared by both sides of the dual-clock FIFO.
// Default address width and depth for the pointer controllers.
package fifo_ptr_pkg;

   localparam int DEF_AW = 4;
   localparam int DEPTH  = 2**DEF_AW;

   function automatic logic [31:0] wmask(input int w);
      return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b,
                                            input int w);
      return (b ^ (b >> 1)) & wmask(w);
   endfunction

   // XOR prefix from the MSB down
   function automatic logic [31:0] gray2bin(input logic [31:0] g,
                                            input int w);
      logic [31:0] b;
      b = g & wmask(w);
      for (int i = w - 2; i >= 0; i--)
         b[i] = b[i+1] ^ b[i];
      return b;
   endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side handshake bundle: write pointer in, read pointer and status out.
// master = consumer side, slave = read pointer controller.
interface async_fifo_rd_ctrl_if
   import fifo_ptr_pkg::*;
#(
   parameter int AW = DEF_AW
) ();

   logic [AW:0]   wr_gptr_async;
   logic          rd_en;
   logic [AW:0]   rd_gptr;
   logic [AW-1:0] rd_addr;
   logic          empty;
   logic [AW:0]   rd_count;
   logic          rd_ok;
   logic          rd_underflow;
   logic          ptr_err;

   modport master (
      output wr_gptr_async, rd_en,
      input  rd_gptr, rd_addr, empty, rd_count,
      input  rd_ok, rd_underflow, ptr_err
   );

   modport slave (
      input  wr_gptr_async, rd_en,
      output rd_gptr, rd_addr, empty, rd_count,
      output rd_ok, rd_underflow, ptr_err
   );

endinterface

// File: rtl/async_fifo_rd_ctrl_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer.
// Reused by the write side to bring rd_gptr across.
module gray_sync #(
   parameter int W      = 5,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] chain [STAGES];

   // shift the Gray value down the chain, cleared by async reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++)
            chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++)
            chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer controller of a dual-clock FIFO.
// Optional occupancy sanity check: define OCC_CHECK_EN.
module async_fifo_rd_ctrl
   import fifo_ptr_pkg::*;
#(
   parameter int AW          = DEF_AW,
   parameter int SYNC_STAGES = 2
) (
   input logic                 clk,
   input logic                 rst,
   async_fifo_rd_ctrl_if.slave bus
);

   localparam logic [AW:0] FULL = (AW+1)'(2**AW);

   logic [AW:0] wr_gptr_s;
   logic [AW:0] wr_bptr_s;
   logic [AW:0] rd_bptr;
   logic [AW:0] rd_bptr_nxt;
   logic [AW:0] rd_gptr_nxt;
   logic [AW:0] rd_gptr_q;
   logic [AW:0] diff;
   logic [AW:0] cnt_nxt;
   logic [AW:0] cnt_q;
   logic        empty_q;
   logic        rd_ok;

   gray_sync #(
      .W      (AW+1),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.wr_gptr_async),
      .q   (wr_gptr_s)
   );

   // pointer arithmetic for this cycle's pop
   always_comb begin
      wr_bptr_s   = (AW+1)'(gray2bin(32'(wr_gptr_s), AW+1));
      rd_ok       = bus.rd_en & ~empty_q;
      rd_bptr_nxt = rd_bptr + {{AW{1'b0}}, rd_ok};
      rd_gptr_nxt = (AW+1)'(bin2gray(32'(rd_bptr_nxt), AW+1));
      diff        = wr_bptr_s - rd_bptr_nxt;
   end

`ifdef OCC_CHECK_EN
   logic err_q;
   logic err_nxt;

   // flag impossible occupancy and clamp the count while flagged
   always_comb begin
      err_nxt = err_q | (diff > FULL);
      cnt_nxt = err_nxt ? FULL : diff;
   end

   // sticky corruption flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_q <= 1'b0;
      else
         err_q <= err_nxt;
   end

   assign bus.ptr_err = err_q;
`else
   // raw occupancy, no checking
   always_comb begin
      cnt_nxt = diff;
   end

   assign bus.ptr_err = 1'b0;
`endif

   // read pointer, its Gray copy, empty and count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_bptr   <= '0;
         rd_gptr_q <= '0;
         empty_q   <= 1'b1;
         cnt_q     <= '0;
      end else begin
         rd_bptr   <= rd_bptr_nxt;
         rd_gptr_q <= rd_gptr_nxt;
         empty_q   <= (rd_gptr_nxt == wr_gptr_s);
         cnt_q     <= cnt_nxt;
      end
   end

   assign bus.rd_gptr      = rd_gptr_q;
   assign bus.rd_addr      = rd_bptr[AW-1:0];
   assign bus.empty        = empty_q;
   assign bus.rd_count     = cnt_q;
   assign bus.rd_ok        = rd_ok;
   assign bus.rd_underflow = bus.rd_en & empty_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for the read-side FIFO pointer controller.
// AW=4, SYNC_STAGES=2; honours OCC_CHECK_EN.
module tb_async_fifo_rd_ctrl;
   import fifo_ptr_pkg::*;

   logic clk;
   logic rst;
   int   ncmp;
   int   nerr;
   int   w;
   int   r;

   async_fifo_rd_ctrl_if #(.AW(4)) bus ();

   async_fifo_rd_ctrl #(
      .AW          (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] g5(input int b);
      logic [4:0] x;
      x = 5'(b);
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setw(input int v);
      w = v;
      bus.wr_gptr_async = g5(v);
   endtask

   initial begin
      ncmp = 0;
      nerr = 0;
      rst = 1'b0;
      bus.rd_en = 1'b1;
      setw(0);
      r = 0;

      // 1. reset with rd_en held
      tick();
      tick();
      chk("rst_gptr", 32'(bus.rd_gptr), 32'd0);
      chk("rst_addr", 32'(bus.rd_addr), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_count", 32'(bus.rd_count), 32'd0);
      chk("rst_ok", 32'(bus.rd_ok), 32'd0);
      chk("rst_err", 32'(bus.ptr_err), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("uf_pulse", 32'(bus.rd_underflow), 32'd1);
         chk("uf_ok", 32'(bus.rd_ok), 32'd0);
         chk("uf_gptr", 32'(bus.rd_gptr), 32'd0);
         chk("uf_empty", 32'(bus.empty), 32'd1);
      end
      bus.rd_en = 1'b0;

      // 2. single write, latency, single pop
      setw(1);
      tick();
      chk("lat_e1", 32'(bus.empty), 32'd1);
      tick();
      chk("lat_e2", 32'(bus.empty), 32'd1);
      tick();
      chk("lat_e3", 32'(bus.empty), 32'd0);
      chk("lat_cnt", 32'(bus.rd_count), 32'd1);
      bus.rd_en = 1'b1;
      #1;
      chk("pop1_ok", 32'(bus.rd_ok), 32'd1);
      chk("pop1_uf", 32'(bus.rd_underflow), 32'd0);
      chk("pop1_a0", 32'(bus.rd_addr), 32'd0);
      tick();
      bus.rd_en = 1'b0;
      chk("pop1_a1", 32'(bus.rd_addr), 32'd1);
      chk("pop1_g", 32'(bus.rd_gptr), 32'd1);
      chk("pop1_empty", 32'(bus.empty), 32'd1);
      chk("pop1_cnt", 32'(bus.rd_count), 32'd0);

      // 3. fill to 16 from a fresh reset, then drain
      rst = 1'b0;
      setw(0);
      tick();
      rst = 1'b1;
      tick();
      for (int i = 1; i <= 16; i++) begin
         setw(i);
         tick();
      end
      tick();
      tick();
      tick();
      chk("full_cnt", 32'(bus.rd_count), 32'd16);
      chk("full_empty", 32'(bus.empty), 32'd0);
      bus.rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("drain_addr", 32'(bus.rd_addr), 32'(i));
         chk("drain_ok", 32'(bus.rd_ok), 32'd1);
         tick();
         chk("drain_cnt", 32'(bus.rd_count), 32'(15 - i));
      end
      bus.rd_en = 1'b0;
      r = 16;
      chk("drain_g", 32'(bus.rd_gptr), 32'h18);
      chk("drain_addr16", 32'(bus.rd_addr), 32'd0);
      chk("drain_empty", 32'(bus.empty), 32'd1);

      // 4. steady write+pop across the 31->0 wrap
      for (int i = 17; i <= 20; i++) begin
         setw(i);
         tick();
      end
      tick();
      tick();
      tick();
      chk("pre_cnt", 32'(bus.rd_count), 32'd4);
      bus.rd_en = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         setw((w + 1) % 32);
         #1;
         chk("wrap_ok", 32'(bus.rd_ok), 32'd1);
         tick();
         r = (r + 1) % 32;
         chk("wrap_cnt", 32'(bus.rd_count), (k == 1) ? 32'd3 : 32'd2);
         chk("wrap_empty", 32'(bus.empty), 32'd0);
         chk("wrap_g", 32'(bus.rd_gptr), 32'(g5(r)));
         chk("wrap_addr", 32'(bus.rd_addr), 32'(r % 16));
      end
      bus.rd_en = 1'b0;
      tick();
      tick();
      tick();
      chk("post_cnt", 32'(bus.rd_count), 32'd4);
      chk("post_r", 32'(r), 32'd24);

      // 5. last-word pop racing a new write
      bus.rd_en = 1'b1;
      tick();
      tick();
      tick();
      bus.rd_en = 1'b0;
      r = 27;
      chk("last_cnt", 32'(bus.rd_count), 32'd1);
      setw(29);
      tick();
      tick();
      chk("race_cnt0", 32'(bus.rd_count), 32'd1);
      bus.rd_en = 1'b1;
      #1;
      chk("race_ok", 32'(bus.rd_ok), 32'd1);
      tick();
      bus.rd_en = 1'b0;
      chk("race_empty", 32'(bus.empty), 32'd0);
      chk("race_cnt", 32'(bus.rd_count), 32'd1);
      chk("race_addr", 32'(bus.rd_addr), 32'd12);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("last_empty", 32'(bus.empty), 32'd1);
      chk("last_cnt0", 32'(bus.rd_count), 32'd0);

      // 6. corrupted pointer crossing
      rst = 1'b0;
      setw(0);
      tick();
      rst = 1'b1;
      setw(20);
      tick();
      tick();
      tick();
      chk("err_empty", 32'(bus.empty), 32'd0);
`ifdef OCC_CHECK_EN
      chk("err_set", 32'(bus.ptr_err), 32'd1);
      chk("err_cnt", 32'(bus.rd_count), 32'(DEPTH));
`else
      chk("err_off", 32'(bus.ptr_err), 32'd0);
      chk("err_cnt", 32'(bus.rd_count), 32'd20);
`endif
      setw(0);
      tick();
      tick();
      tick();
`ifdef OCC_CHECK_EN
      chk("err_sticky", 32'(bus.ptr_err), 32'd1);
      chk("err_sat", 32'(bus.rd_count), 32'(DEPTH));
`else
      chk("err_off2", 32'(bus.ptr_err), 32'd0);
      chk("err_cnt0", 32'(bus.rd_count), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
